// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes engine.
// LANES S-boxes per cycle; 16/LANES cycles per state.
module sub_bytes_engine #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCH = 16 / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((16 % LANES) != 0) begin : g_bad
    $error("sub_bytes_engine: LANES must divide 16");
  end

  // Entry 0 sits in the top byte, so index with ~{x,3'b0}.
  localparam logic [2047:0] FWD_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q, work_d;
  logic [127:0]    out_q;
  logic            mode_q;
  logic            init_q;
  logic            accept;
  logic            last;
  logic [3:0]      base;
  logic [7:0]      dout [LANES];

  assign in_ready  = (state_q == IDLE) & init_q;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;
  assign last      = (cnt_q == CW'(NCH - 1));
  assign base      = 4'(int'(cnt_q) * LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0]  din;
    logic [7:0]  fo;
    logic [10:0] idx;
    assign din = work_q[8*(int'(base)+j) +: 8];
    assign idx = ~{din, 3'b000};
    assign fo  = FWD_T[idx -: 8];
    if (INV_EN != 0) begin : g_inv
      localparam logic [2047:0] INV_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
      };
      assign dout[j] = mode_q ? INV_T[idx -: 8] : fo;
    end else begin : g_fwd
      assign dout[j] = fo;
    end
  end

  always_comb begin
    work_d = work_q;
    for (int j = 0; j < LANES; j++) begin
      work_d[8*(int'(base)+j) +: 8] = dout[j];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      if (accept) begin
        work_q <= in_state;
        mode_q <= (INV_EN != 0) && in_inv;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        work_q <= work_d;
        cnt_q  <= cnt_q + 1'b1;
        // Result register only moves on completion.
        if (last) out_q <= work_d;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: four instances (LANES 1/4/16/8,
// the last without inverse support) driven in lockstep.
module tb_sub_bytes_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;

  logic         i_ready [4];
  logic         o_valid [4];
  logic         bsy     [4];
  logic [127:0] o_state [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sub_bytes_engine #(
      .LANES (g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 16 : 8),
      .INV_EN(g == 3 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (i_ready[g]),
      .in_state (in_state),
      .in_inv   (in_inv),
      .out_valid(o_valid[g]),
      .out_ready(out_ready),
      .out_state(o_state[g]),
      .busy     (bsy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;
  logic [7:0]   fm [256];
  logic [7:0]   im [256];
  logic [127:0] res [4];

  function automatic int lat_of(int k);
    int ln;
    ln = (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 16 : 8;
    return 16 / ln;
  endfunction

  function automatic logic [3:0] pk(input logic a [4]);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3)
             ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] expect_st(
    logic [127:0] st, logic md, int k);
    logic [127:0] r;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = st[8*i +: 8];
      r[8*i +: 8] = (md && k != 3) ? im[b] : fm[b];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic txn(logic [127:0] st, logic inv, bit noisy);
    int cyc;
    bit seen [4];
    int lat [4];
    logic [127:0] snap [4];
    cyc = 0;
    while (pk(i_ready) != 4'hf && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_wait", 128'(pk(i_ready)), 128'hf);
    in_valid = 1'b1;
    in_state = st;
    in_inv = inv;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv = ~inv;
    chk("busy_after_accept", 128'(pk(bsy)), 128'hf);
    for (int k = 0; k < 4; k++) begin
      seen[k] = 1'b0;
      lat[k] = -1;
      snap[k] = '0;
    end
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3])
           && cyc < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom);
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_inv = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      chk("ready_low_run", 128'(pk(i_ready)), 128'h0);
      for (int k = 0; k < 4; k++)
        if (o_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          lat[k] = cyc;
          snap[k] = o_state[k];
        end
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("latency%0d", k), 128'(lat[k]),
          128'(lat_of(k)));
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 128'(pk(o_valid)), 128'hf);
      chk("hold_ready", 128'(pk(i_ready)), 128'h0);
      for (int k = 0; k < 4; k++)
        chk($sformatf("hold_state%0d", k), o_state[k], snap[k]);
    end
    in_valid = noisy;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("valid_drop", 128'(pk(o_valid)), 128'h0);
    chk("no_accept_at_done", 128'(pk(bsy)), 128'h0);
    chk("ready_after", 128'(pk(i_ready)), 128'hf);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("keep_state%0d", k), o_state[k], snap[k]);
      res[k] = snap[k];
    end
  endtask

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
    logic [127:0] expn;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [127:0] st;
    logic [127:0] fr;
    vt[0] = '{128'h0, 1'b0, {16{8'h63}}, {16{8'h63}}};
    vt[1] = '{128'h53, 1'b0, {{15{8'h63}}, 8'hed},
              {{15{8'h63}}, 8'hed}};
    vt[2] = '{{16{8'h63}}, 1'b1, 128'h0, {16{8'hfb}}};
    vt[3] = '{{16{8'h16}}, 1'b1, {16{8'hff}}, {16{8'h47}}};
    vt[4] = '{128'hffeeddccbbaa99887766554433221100, 1'b0,
              128'h1628c14beaaceec4f533fc1bc3938263,
              128'h1628c14beaaceec4f533fc1bc3938263};

    for (int v = 0; v < 256; v++) fm[v] = sbox(8'(v));
    for (int v = 0; v < 256; v++) im[fm[v]] = 8'(v);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    in_inv = 1'b0;
    out_ready = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk("rst_ready", 128'(i_ready[k]), 128'h0);
      chk("rst_valid", 128'(o_valid[k]), 128'h0);
      chk("rst_busy", 128'(bsy[k]), 128'h0);
      chk("rst_state", o_state[k], 128'h0);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ready_in_reset", 128'(pk(i_ready)), 128'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 128'(pk(i_ready)), 128'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ready_first_edge", 128'(pk(i_ready)), 128'hf);
    chk("out_ready_idle", 128'(pk(o_valid)), 128'h0);

    for (int i = 0; i < 5; i++) begin
      txn(vt[i].st, vt[i].inv, i[0]);
      for (int k = 0; k < 4; k++)
        chk($sformatf("vec%0d_dut%0d", i, k), res[k],
            (k == 3) ? vt[i].expn : vt[i].exp);
    end

    for (int v = 0; v < 256; v++) begin
      st = {16{8'(v)}};
      txn(st, 1'b0, v[0]);
      for (int k = 0; k < 4; k++)
        chk($sformatf("fwd%0d_%0d", v, k), res[k],
            expect_st(st, 1'b0, k));
      fr = res[1];
      txn(st, 1'b1, v[1]);
      for (int k = 0; k < 4; k++)
        chk($sformatf("inv%0d_%0d", v, k), res[k],
            expect_st(st, 1'b1, k));
      txn(fr, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++)
        chk($sformatf("round%0d_%0d", v, k), res[k], st);
    end

    // Abort mid-run: LANES=4 instance is in chunk 2.
    in_valid = 1'b1;
    in_state = {16{8'h5a}};
    in_inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_was_busy", 128'(bsy[1]), 128'h1);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("abort_valid", 128'(o_valid[k]), 128'h0);
      chk("abort_busy", 128'(bsy[k]), 128'h0);
      chk("abort_state", o_state[k], 128'h0);
      chk("abort_ready", 128'(i_ready[k]), 128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_back", 128'(pk(i_ready)), 128'hf);
    txn(128'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      chk("abort_fresh", res[k], {16{8'h63}});

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of S-box lanes evaluated per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The block SHALL have parameter INV_EN, default 1, meaning inverse-S-box support is built when 1 and omitted when 0.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  an input state is offered.
REQ-006 Port in_ready  output  1  the block can accept an input state.
REQ-007 Port in_state  input  128  the AES state; byte i occupies bits [8i+7:8i], for i = 0..15.
REQ-008 Port in_inv  input  1  mode select: 0 = SubBytes, 1 = InvSubBytes.
REQ-009 Port out_valid  output  1  out_state holds a completed result.
REQ-010 Port out_ready  input  1  the consumer accepts the result.
REQ-011 Port out_state  output  128  the substituted state, using the same byte mapping as in_state.
REQ-012 Port busy  output  1  high while in RUN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 An accept SHALL occur when in_valid and in_ready are both 1 at a clock edge.
REQ-016 On accept, the block SHALL:
- latch in_state into the working register;
- latch in_inv, forced to 0 when INV_EN = 0;
- clear the chunk counter;
- move to RUN.
REQ-017 In RUN, each cycle SHALL substitute bytes k*LANES through k*LANES+LANES-1 of the working register in place, where k is the counter value, and then increment k.
REQ-018 The counter width SHALL be log2(16/LANES), minimum 1 bit.
REQ-019 The FSM SHALL leave RUN for DONE on the edge that processes chunk 16/LANES-1.
REQ-020 Latency SHALL be fixed:
- accept at edge T gives out_valid = 1 after edge T + 16/LANES;
- LANES = 4 gives 4 cycles; LANES = 16 gives 1 cycle; LANES = 1 gives 16 cycles.
REQ-021 The forward S-box SHALL match FIPS-197 Figure 7 bit-exactly.
REQ-022 The inverse S-box SHALL match FIPS-197 Figure 14 bit-exactly.
REQ-023 The S-boxes SHALL be purely combinational inside each lane.
REQ-024 In DONE, out_valid SHALL be 1 and out_state SHALL equal the working register.
REQ-025 out_state SHALL remain stable until the handshake completes, whatever the state of out_ready.
REQ-026 When out_valid and out_ready are both 1 at an edge, the FSM SHALL return to IDLE.
REQ-027 out_valid SHALL fall in the cycle after the output handshake.
REQ-028 out_state SHALL keep its last value until the next completion.
REQ-029 in_valid asserted while in RUN or DONE SHALL be ignored, with no capture and no state change.
REQ-030 Changes on in_state or in_inv after accept SHALL NOT affect the result in progress.
REQ-031 out_ready asserted in IDLE or RUN SHALL have no effect.
REQ-032 The block SHALL never accept a new input in the same cycle that it delivers an output.
REQ-033 A LANES value that does not divide 16 SHALL stop elaboration with an error.
REQ-034 When INV_EN = 0, in_inv SHALL be ignored and no inverse table SHALL be synthesised.

Reset
REQ-035 rst_n = 0 SHALL immediately, without waiting for clk, force the following:
- FSM to IDLE;
- counter = 0;
- working register = 0;
- latched mode = 0;
- out_valid = 0;
- busy = 0;
- out_state = 0.
REQ-036 While rst_n = 0, in_ready SHALL be 0.
REQ-037 in_ready SHALL become 1 on the first edge after rst_n goes high.
REQ-038 Reset asserted during RUN or DONE SHALL abort the operation with no partial result presented.
REQ-039 After reset is released, the next accepted input SHALL be processed normally.

Verification
REQ-040 Known vectors, LANES = 4, forward mode:
- in_state = 128'h0 -> out_state = 128'h6363...63 (all bytes 8'h63);
- a state with byte0 = 8'h53 -> byte0 = 8'hED.
REQ-041 Inverse mode:
- all bytes 8'h63, in_inv = 1 -> all bytes 8'h00;
- all bytes 8'h16 -> all bytes 8'hFF.
REQ-042 Full sweep:
- for each v in 0..255, drive all 16 bytes = v in both modes;
- check every byte against the FIPS table;
- check that inverse(forward(v)) = v.
REQ-043 Latency and backpressure, for LANES in {1, 4, 16}:
- out_valid rises exactly 16/LANES cycles after accept;
- hold out_ready = 0 for 5 cycles -> out_valid and out_state stay stable, and in_ready stays 0 throughout.
REQ-044 Busy-time inputs:
- toggle in_valid, in_state and in_inv during RUN -> the result equals that of the originally accepted input;
- back-to-back inputs are accepted only after the output handshake.
REQ-045 Reset mid-operation:
- assert rst_n = 0 between clock edges during chunk 2 of RUN -> out_valid = 0, busy = 0 and out_state = 0 immediately;
- after release, a fresh all-8'h00 input yields all-8'h63.
